// File: rtl/multiplier_16bit_seq_if.sv
// Request/result bundle for the sequential 16x16 multiplier.
// master: requester (drives start and operands); slave: the multiplier.
interface multiplier_16bit_seq_if;
    logic        start;
    logic [15:0] multiplicand;
    logic [15:0] multiplier;
    logic        busy;
    logic        done;
    logic [31:0] product;
    logic        overflow;

    modport master (
        output start, multiplicand, multiplier,
        input  busy, done, product, overflow
    );

    modport slave (
        input  start, multiplicand, multiplier,
        output busy, done, product, overflow
    );
endinterface

// File: rtl/multiplier_16bit_seq.sv
// Sequential 16x16 shift-add multiplier with a fixed 17-cycle latency.
// The result becomes visible in the cycle where done is high.
// Build option: define MULTIPLIER_SIGNED_EN to treat operands as two's
// complement. Magnitudes are multiplied and the result is negated when
// the signs differ. Ports and latency are the same in both builds.
module multiplier_16bit_seq (
    input logic                    clk,
    input logic                    rst,
    multiplier_16bit_seq_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t      state, next_state;
    logic        accept;
    logic        busy_c, done_c;
    logic [3:0]  cnt;
    logic [31:0] acc;
    logic [31:0] mcand_sh;   // multiplicand shifted left once per step
    logic [15:0] mplier_sh;  // multiplier shifted right once per step
    logic [31:0] product_q;
    logic        overflow_q;
    logic [31:0] acc_next;
    logic [31:0] result;
    logic        result_ovf;
    logic [15:0] a_op, b_op;

`ifdef MULTIPLIER_SIGNED_EN
    logic neg_q;
    // Convert both operands to magnitudes; 0x8000 maps to 0x8000 unsigned.
    always_comb begin
        a_op = bus.multiplicand[15] ? (16'd0 - bus.multiplicand) : bus.multiplicand;
        b_op = bus.multiplier[15]   ? (16'd0 - bus.multiplier)   : bus.multiplier;
    end
`else
    assign a_op = bus.multiplicand;
    assign b_op = bus.multiplier;
`endif

    // One shift-add step; the last step's sum goes straight to the output
    // registers so that no bits are lost and the latency stays fixed.
    assign acc_next = acc + (mplier_sh[0] ? mcand_sh : 32'd0);

`ifdef MULTIPLIER_SIGNED_EN
    assign result     = neg_q ? (32'd0 - acc_next) : acc_next;
    assign result_ovf = !((&result[31:15]) || !(|result[31:15]));
`else
    assign result     = acc_next;
    assign result_ovf = |result[31:16];
`endif

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // Next-state, start acceptance and status outputs.
    always_comb begin
        next_state = state;
        accept     = 1'b0;
        busy_c     = 1'b0;
        done_c     = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    accept     = 1'b1;
                    next_state = CALC;
                end
            end
            CALC: begin
                busy_c = 1'b1;
                if (cnt == 4'd15) next_state = DONE;
            end
            DONE: begin
                done_c = 1'b1;
                if (bus.start) begin
                    accept     = 1'b1;
                    next_state = CALC;
                end else begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Operand latch, shift-add datapath and held result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt        <= '0;
            acc        <= '0;
            mcand_sh   <= '0;
            mplier_sh  <= '0;
            product_q  <= '0;
            overflow_q <= 1'b0;
`ifdef MULTIPLIER_SIGNED_EN
            neg_q      <= 1'b0;
`endif
        end else if (accept) begin
            cnt        <= '0;
            acc        <= '0;
            mcand_sh   <= {16'd0, a_op};
            mplier_sh  <= b_op;
`ifdef MULTIPLIER_SIGNED_EN
            neg_q      <= bus.multiplicand[15] ^ bus.multiplier[15];
`endif
        end else if (state == CALC) begin
            cnt       <= cnt + 4'd1;
            acc       <= acc_next;
            mcand_sh  <= {mcand_sh[30:0], 1'b0};
            mplier_sh <= {1'b0, mplier_sh[15:1]};
            if (cnt == 4'd15) begin
                product_q  <= result;
                overflow_q <= result_ovf;
            end
        end
    end

    assign bus.busy     = busy_c;
    assign bus.done     = done_c;
    assign bus.product  = product_q;
    assign bus.overflow = overflow_q;
endmodule

// File: doc/multiplier_16bit_seq.md
MULTIPLIER_16BIT_SEQ -- requirements
Module: multiplier_16bit_seq

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset; ports are listed below, clock and reset first.
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-high reset
- start  input  1  request pulse; operands sampled when accepted
- multiplicand  input  16  operand A
- multiplier  input  16  operand B
- busy  output  1  high while a multiply is in progress
- done  output  1  one-cycle pulse, product/overflow valid
- product  output  32  A*B result, held until next completion
- overflow  output  1  result not representable in 16 bits

Function
REQ-002 FSM states SHALL be IDLE, CALC, DONE; reset state IDLE.
REQ-003 Start acceptance SHALL occur when start=1 in IDLE or DONE: latch both operands, clear accumulator, counter=0, next state CALC.
REQ-004 start SHALL be ignored in CALC; latched operands SHALL NOT change mid-operation.
REQ-005 CALC SHALL perform one shift-add step per cycle on the LSB of the shifted multiplier, for exactly 16 cycles (counter 0..15), then go to DONE.
REQ-006 Latency SHALL be fixed: done=1 in the 17th cycle after the accepting cycle, independent of operand values (no early termination for zero operands).
REQ-007 busy SHALL be 1 exactly in CALC; done SHALL be 1 exactly in DONE.
REQ-008 product and overflow SHALL update only on entry to DONE and SHALL hold until the next DONE entry or reset.
REQ-009 DONE SHALL last one cycle, going to CALC if start=1 (back-to-back), else IDLE.
REQ-010 Internal accumulator SHALL be 32 bits wide; no bits SHALL be lost.
REQ-011 Unsigned mode: overflow = (product[31:16] != 0).

Reset
REQ-012 rst=1 SHALL asynchronously force IDLE, busy=0, done=0, product=0, overflow=0, counter/accumulator/latched operands cleared.
REQ-013 Reset asserted mid-CALC SHALL abort the operation; no done pulse SHALL follow after release.
REQ-014 After reset release, the first accepted start SHALL behave identically to a start following an idle period.

Configuration
REQ-015 Macro MULTIPLIER_SIGNED_EN SHALL select operand interpretation; ports and latency SHALL be identical in both builds.
REQ-016 Defined: operands are two's complement; magnitudes multiplied over the same 16 cycles, result negated on entry to DONE when signs differ; overflow = product not in range -32768..32767 (bits [31:15] not all equal).
REQ-017 Undefined: operands unsigned, overflow per REQ-011; no sign logic synthesized.

Verification
REQ-018 A=3, B=5, start pulsed from IDLE -> busy for 16 cycles, done in 17th cycle, product=0x0000000F, overflow=0.
REQ-019 A=0xFFFF, B=0xFFFF, unsigned build -> product=0xFFFE0001, overflow=1; signed build -> product=0x00000001, overflow=0.
REQ-020 A=0xFFFD, B=0x0007 -> signed build product=0xFFFFFFEB, overflow=0; unsigned build product=0x0006FFEB, overflow=1.
REQ-021 start=1 with A=9, B=9 during CALC of 3*5 -> ignored; result 0x0000000F, exactly one done pulse.
REQ-022 start held at DONE with A=2, B=4 -> immediate back-to-back; second done 17 cycles later, product=0x00000008; first product held in between.
REQ-023 rst pulsed at CALC cycle 8 -> outputs zero immediately, no done afterwards; subsequent A=0, B=0x1234 -> product=0, overflow=0, latency 17.
